// File: rtl/keypad_calc.sv
// Two-operand BCD add/subtract keypad entry FSM driving four display digit codes.
// Optional macro KEYCALC_CHAIN_EN: add/sub in RESULT chains a small positive result into A.
module keypad_calc (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key,
  input  logic       pressed,
  input  logic       add,
  input  logic       sub,
  output logic [3:0] in0,
  output logic [3:0] in1,
  output logic [3:0] in2,
  output logic [3:0] in3,
  output logic [1:0] op_out,
  output logic [1:0] state_out
);

  localparam int unsigned DW = 4;
  localparam logic [DW-1:0] BLANK_CODE = 4'hF;
  localparam logic [DW-1:0] MINUS_CODE = 4'hA;
  localparam logic [DW-1:0] CLR_KEY    = 4'hC;
  localparam logic [DW-1:0] EQ_KEY     = 4'hF;
  localparam logic [1:0]    OP_NONE    = 2'b00;
  localparam logic [1:0]    OP_ADD     = 2'b01;
  localparam logic [1:0]    OP_SUB     = 2'b10;

  typedef enum logic [1:0] {
    ENTER_A = 2'b00,
    ENTER_B = 2'b01,
    RESULT  = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    a_q, a_d, b_q, b_d;
  logic [1:0]    op_q, op_d;
  logic [DW-1:0] h_q, h_d, t_q, t_d, o_q, o_d;
  logic          neg_q, neg_d;
  logic [DW-1:0] in0_q, in0_d, in1_q, in1_d, in2_q, in2_d, in3_q, in3_d;
  logic          pressed_q, add_q, sub_q;

  logic          kev, aev, sev, pb_ev;
  logic          is_clr, is_eq, is_dig;
  logic [1:0]    pb_op;
  logic [6:0]    a_bin, b_bin, rem, t_bin, o_bin;
  logic [7:0]    r_bin;
  logic          r_neg, r_hund;

  // Single-cycle events from rising edges of the level inputs
  assign kev    = pressed & ~pressed_q;
  assign aev    = add & ~add_q;
  assign sev    = sub & ~sub_q;
  assign pb_ev  = aev | sev;
  assign pb_op  = aev ? OP_ADD : OP_SUB;
  assign is_clr = kev && (key == CLR_KEY);
  assign is_eq  = kev && (key == EQ_KEY);
  assign is_dig = kev && (key <= 4'd9);

  // Binary arithmetic on the latched operands, then back to BCD
  always_comb begin
    a_bin = 7'(a_q[7:4]) * 7'd10 + 7'(a_q[3:0]);
    b_bin = 7'(b_q[7:4]) * 7'd10 + 7'(b_q[3:0]);
    r_neg = 1'b0;
    if (op_q == OP_SUB) begin
      if (a_bin < b_bin) begin
        r_bin = 8'(b_bin - a_bin);
        r_neg = 1'b1;
      end else begin
        r_bin = 8'(a_bin - b_bin);
      end
    end else begin
      r_bin = 8'(a_bin) + 8'(b_bin);
    end
    r_hund = (r_bin >= 8'd100);
    rem    = r_hund ? 7'(r_bin - 8'd100) : 7'(r_bin);
    t_bin  = rem / 7'd10;
    o_bin  = rem - t_bin * 7'd10;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    h_d     = h_q;
    t_d     = t_q;
    o_d     = o_q;
    neg_d   = neg_q;
    if (!(state_q inside {ENTER_A, ENTER_B, RESULT})) state_d = ENTER_A;

    // Priority: clear key, then push buttons, then digit/equals keys
    if (is_clr) begin
      state_d = ENTER_A;
      a_d     = 8'd0;
      b_d     = 8'd0;
      op_d    = OP_NONE;
      h_d     = 4'd0;
      t_d     = 4'd0;
      o_d     = 4'd0;
      neg_d   = 1'b0;
    end else if (pb_ev) begin
      case (state_q)
        ENTER_A: begin
          op_d    = pb_op;
          b_d     = 8'd0;
          state_d = ENTER_B;
        end
        ENTER_B: op_d = pb_op;
        RESULT: begin
`ifdef KEYCALC_CHAIN_EN
          if (!neg_q && (h_q == 4'd0)) begin
            a_d     = {t_q, o_q};
            b_d     = 8'd0;
            op_d    = pb_op;
            state_d = ENTER_B;
          end
`endif
        end
        default: ;
      endcase
    end else if (is_dig) begin
      case (state_q)
        ENTER_A: a_d = {a_q[3:0], key};
        ENTER_B: b_d = {b_q[3:0], key};
        RESULT: begin
          a_d     = {4'd0, key};
          b_d     = 8'd0;
          op_d    = OP_NONE;
          state_d = ENTER_A;
        end
        default: ;
      endcase
    end else if (is_eq && (state_q == ENTER_B)) begin
      state_d = RESULT;
      h_d     = r_hund ? 4'd1 : 4'd0;
      t_d     = 4'(t_bin);
      o_d     = 4'(o_bin);
      neg_d   = r_neg;
    end
  end

  // Display follows the next state so it updates on the same edge as the FSM
  always_comb begin
    in3_d = BLANK_CODE;
    in2_d = BLANK_CODE;
    in1_d = a_d[7:4];
    in0_d = a_d[3:0];
    case (state_d)
      ENTER_B: begin
        in3_d = a_d[7:4];
        in2_d = a_d[3:0];
        in1_d = b_d[7:4];
        in0_d = b_d[3:0];
      end
      RESULT: begin
        in3_d = neg_d ? MINUS_CODE : BLANK_CODE;
        in2_d = h_d;
        in1_d = t_d;
        in0_d = o_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ENTER_A;
      a_q       <= 8'd0;
      b_q       <= 8'd0;
      op_q      <= OP_NONE;
      h_q       <= 4'd0;
      t_q       <= 4'd0;
      o_q       <= 4'd0;
      neg_q     <= 1'b0;
      in3_q     <= BLANK_CODE;
      in2_q     <= BLANK_CODE;
      in1_q     <= 4'd0;
      in0_q     <= 4'd0;
      pressed_q <= 1'b0;
      add_q     <= 1'b0;
      sub_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      h_q       <= h_d;
      t_q       <= t_d;
      o_q       <= o_d;
      neg_q     <= neg_d;
      in3_q     <= in3_d;
      in2_q     <= in2_d;
      in1_q     <= in1_d;
      in0_q     <= in0_d;
      pressed_q <= pressed;
      add_q     <= add;
      sub_q     <= sub;
    end
  end

  assign in0       = in0_q;
  assign in1       = in1_q;
  assign in2       = in2_q;
  assign in3       = in3_q;
  assign op_out    = op_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_keypad_calc.sv
// Directed self-checking bench for keypad_calc; honours KEYCALC_CHAIN_EN when defined.
module tb_keypad_calc;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key;
  logic       pressed, add, sub;
  logic [3:0] in0, in1, in2, in3;
  logic [1:0] op_out, state_out;
  int         checks = 0;
  int         errors = 0;

  keypad_calc dut (
    .clk(clk), .rst(rst), .key(key), .pressed(pressed), .add(add), .sub(sub),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3), .op_out(op_out), .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic [1:0] op,
                           input logic [15:0] disp);
    check({tag, ".state"}, 16'(state_out), 16'(st));
    check({tag, ".op"}, 16'(op_out), 16'(op));
    check({tag, ".disp"}, {in3, in2, in1, in0}, disp);
  endtask

  task automatic hold_key(input logic [3:0] k, input int n);
    @(negedge clk);
    key = k;
    pressed = 1'b1;
    repeat (n) @(negedge clk);
    pressed = 1'b0;
  endtask

  task automatic tap_key(input logic [3:0] k);
    hold_key(k, 1);
  endtask

  task automatic tap_btn(input logic a, input logic s);
    @(negedge clk);
    add = a;
    sub = s;
    @(negedge clk);
    add = 1'b0;
    sub = 1'b0;
  endtask

  initial begin
    rst = 1'b1; key = 4'h0; pressed = 1'b0; add = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    check_all("reset", 2'b00, 2'b00, 16'hFF00);
    rst = 1'b0;

    // 42 + 17 = 059
    tap_key(4'd4); tap_key(4'd2);
    check_all("a42", 2'b00, 2'b00, 16'hFF42);
    tap_btn(1'b1, 1'b0);
    check_all("add_enter_b", 2'b01, 2'b01, 16'h4200);
    tap_key(4'd1); tap_key(4'd7);
    check_all("b17", 2'b01, 2'b01, 16'h4217);
    tap_key(4'hF);
    check_all("res059", 2'b10, 2'b01, 16'hF059);

    tap_btn(1'b1, 1'b0);
`ifdef KEYCALC_CHAIN_EN
    check_all("chain", 2'b01, 2'b01, 16'h5900);
    tap_key(4'd3);
    check_all("chain_b3", 2'b01, 2'b01, 16'h5903);
`else
    check_all("no_chain", 2'b10, 2'b01, 16'hF059);
    tap_key(4'd3);
    check_all("res_digit", 2'b00, 2'b00, 16'hFF03);
`endif
    tap_key(4'hC);
    check_all("clr_mid", 2'b00, 2'b00, 16'hFF00);

    // 15 - 99 = -084, then 99 + 99 = 198
    tap_key(4'd1); tap_key(4'd5);
    tap_btn(1'b0, 1'b1);
    check_all("sub_enter_b", 2'b01, 2'b10, 16'h1500);
    tap_key(4'd9); tap_key(4'd9); tap_key(4'hF);
    check_all("res_neg84", 2'b10, 2'b10, 16'hA084);
    tap_btn(1'b1, 1'b0);
    check_all("neg_pb_ignored", 2'b10, 2'b10, 16'hA084);
    tap_key(4'd9);
    check_all("res_to_a", 2'b00, 2'b00, 16'hFF09);
    tap_key(4'd9);
    tap_btn(1'b1, 1'b1);
    check_all("add_beats_sub", 2'b01, 2'b01, 16'h9900);
    tap_key(4'd9); tap_key(4'd9); tap_key(4'hF);
    check_all("res198", 2'b10, 2'b01, 16'hF198);
    tap_key(4'hF);
    check_all("eq_in_result", 2'b10, 2'b01, 16'hF198);
    tap_key(4'hA);
    check_all("key_a_ignored", 2'b10, 2'b01, 16'hF198);
    tap_key(4'hC);
    check_all("clr_result", 2'b00, 2'b00, 16'hFF00);

    // Shift drops the tens digit; a held key shifts once
    tap_key(4'd3); tap_key(4'd4); tap_key(4'd5);
    check_all("a45", 2'b00, 2'b00, 16'hFF45);
    hold_key(4'd6, 10);
    check_all("held_once", 2'b00, 2'b00, 16'hFF56);

    // EQ ignored in ENTER_A; button beats a simultaneous digit
    tap_key(4'hC); tap_key(4'd7);
    tap_key(4'hF);
    check_all("eq_in_a", 2'b00, 2'b00, 16'hFF07);
    @(negedge clk);
    key = 4'd7; pressed = 1'b1; add = 1'b1;
    @(negedge clk);
    pressed = 1'b0; add = 1'b0;
    check_all("pb_beats_digit", 2'b01, 2'b01, 16'h0700);
    tap_btn(1'b0, 1'b1);
    check_all("replace_op", 2'b01, 2'b10, 16'h0700);

    // Clear beats a simultaneous button
    @(negedge clk);
    key = 4'hC; pressed = 1'b1; sub = 1'b1;
    @(negedge clk);
    pressed = 1'b0; sub = 1'b0;
    check_all("clr_beats_pb", 2'b00, 2'b00, 16'hFF00);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
